// File: rtl/lamp_sequence_checker.sv
// Passive checker for the flasher's thermometer lamp bus: decodes level, direction, peaks/troughs and tracks the bound-flash sequence.
// Latency: every output is registered and reflects the lamp sample taken on the previous rising clk edge.
// Backpressure: none; the lamp bus is observed on every cycle and is never stalled.
//
// Ports:
//   clk, rst_n      clock (rising edge) and synchronous active-low reset
//   lamp            observed NUM_LAMP-wide thermometer lamp bus
//   level, dir      lit-lamp count and direction (2'b10 up, 2'b01 down, 2'b00 hold) of the last accepted sample
//   therm_err       pulse: the sample is not a legal thermometer code (2^k-1)
//   step_err        pulse: the accepted level moved by more than one lamp
//   peak_valid      pulse: the direction left UP
//   trough_valid    pulse: the direction left DOWN
//   ext_level       level of the most recent peak or trough
//   seq_state       sequence tracker state
//   cycle_done      pulse: the full sequence 16->5->10->0->5->0 completed
//   seq_err         pulse: an extremum arrived that the sequence does not allow
//   cycle_cnt       completed sequences (stats build only, otherwise 0)
//   err_cnt         cycles with any therm/step/seq error (stats build only, otherwise 0)
//
// Build option: define LAMP_SEQ_STATS_EN to enable the saturating cycle_cnt/err_cnt counters.
// LVL_W must be wide enough to hold NUM_LAMP.

module lamp_sequence_checker #(
    parameter int NUM_LAMP = 16,
    parameter int MID_LO   = 5,
    parameter int MID_HI   = 10,
    parameter int LVL_W    = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_LAMP-1:0] lamp,
    output logic [LVL_W-1:0]    level,
    output logic [1:0]          dir,
    output logic                therm_err,
    output logic                step_err,
    output logic                peak_valid,
    output logic                trough_valid,
    output logic [LVL_W-1:0]    ext_level,
    output logic [2:0]          seq_state,
    output logic                cycle_done,
    output logic                seq_err,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_DOWN = 2'b01;
    localparam logic [1:0] DIR_UP   = 2'b10;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(NUM_LAMP);
    localparam logic [LVL_W-1:0] LVL_LO   = LVL_W'(MID_LO);
    localparam logic [LVL_W-1:0] LVL_HI   = LVL_W'(MID_HI);
    localparam logic [LVL_W-1:0] LVL_ZERO = '0;

    // Each state names the extremum it is waiting for next.
    typedef enum logic [2:0] {
        S_WAIT = 3'd0,  // waiting for the full-scale peak
        S_T1   = 3'd1,  // waiting for trough at MID_LO
        S_P2   = 3'd2,  // waiting for peak at MID_HI
        S_T2   = 3'd3,  // waiting for trough at 0
        S_P3   = 3'd4,  // waiting for peak at MID_LO
        S_T3   = 3'd5   // waiting for final trough at 0
    } seq_state_e;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [LVL_W-1:0] level_q;
    logic [1:0]       dir_q;
    logic             therm_err_q;
    logic             step_err_q;
    logic             peak_q;
    logic             trough_q;
    logic [LVL_W-1:0] ext_level_q;
    seq_state_e       state_q;
    logic             done_q;
    logic             seq_err_q;

    // ------------------------------------------------------------------
    // Sample decode
    // ------------------------------------------------------------------
    logic             lamp_valid;
    logic [LVL_W-1:0] new_lvl;
    logic [1:0]       new_dir;
    logic [LVL_W-1:0] lvl_diff;
    logic             step_big;
    logic             peak_d;
    logic             trough_d;

    always_comb begin
        // A thermometer code has no zero below its top one, so adding one
        // carries through every set bit and clears them all.  The all-ones
        // bus wraps to zero, which is also accepted.
        lamp_valid = ((lamp & (lamp + NUM_LAMP'(1))) == '0);

        new_lvl = '0;
        for (int i = 0; i < NUM_LAMP; i++) begin
            new_lvl = new_lvl + {{(LVL_W-1){1'b0}}, lamp[i]};
        end

        if (new_lvl > level_q) begin
            new_dir  = DIR_UP;
            lvl_diff = new_lvl - level_q;
        end else if (new_lvl < level_q) begin
            new_dir  = DIR_DOWN;
            lvl_diff = level_q - new_lvl;
        end else begin
            new_dir  = DIR_HOLD;
            lvl_diff = '0;
        end

        step_big = lamp_valid && (lvl_diff > LVL_W'(1));

        // Extrema are judged against the direction held before this sample,
        // so an immediate UP->DOWN turn produces only the peak.
        peak_d   = lamp_valid && (dir_q == DIR_UP)   && (new_dir != DIR_UP);
        trough_d = lamp_valid && (dir_q == DIR_DOWN) && (new_dir != DIR_DOWN);
    end

    // ------------------------------------------------------------------
    // Sequence tracker next state.  The extremum level is always the level
    // held before this sample, even when the sample also trips step_err.
    // ------------------------------------------------------------------
    seq_state_e state_d;
    logic       done_d;
    logic       seq_err_d;
    logic       any_evt;

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        seq_err_d = 1'b0;
        any_evt   = peak_d | trough_d;

        if (any_evt) begin
            case (state_q)
                S_T1: begin
                    if (trough_d && level_q == LVL_LO) begin
                        state_d = S_P2;
                    end else begin
                        state_d   = S_WAIT;
                        seq_err_d = 1'b1;
                    end
                end
                S_P2: begin
                    if (peak_d && level_q == LVL_HI) begin
                        state_d = S_T2;
                    end else if (peak_d && level_q == LVL_FULL) begin
                        // Flasher flicked back up to full scale: restart phase 1.
                        state_d = S_T1;
                    end else begin
                        state_d   = S_WAIT;
                        seq_err_d = 1'b1;
                    end
                end
                S_T2: begin
                    if (trough_d && level_q == LVL_ZERO) begin
                        state_d = S_P3;
                    end else begin
                        state_d   = S_WAIT;
                        seq_err_d = 1'b1;
                    end
                end
                S_P3: begin
                    if (peak_d && level_q == LVL_LO) begin
                        state_d = S_T3;
                    end else if (peak_d && level_q == LVL_HI) begin
                        // Flick re-climb to MID_HI: back to waiting for trough 0.
                        state_d = S_T2;
                    end else begin
                        state_d   = S_WAIT;
                        seq_err_d = 1'b1;
                    end
                end
                S_T3: begin
                    if (trough_d && level_q == LVL_ZERO) begin
                        state_d = S_WAIT;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_WAIT;
                        seq_err_d = 1'b1;
                    end
                end
                default: begin
                    // S_WAIT and the unused codes: lock on to the full-scale
                    // peak and silently ignore everything else, so a monitor
                    // reset mid-sequence resynchronises without false errors.
                    if (peak_d && level_q == LVL_FULL) begin
                        state_d = S_T1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            endcase
        end else if (state_q != S_WAIT && state_q != S_T1 && state_q != S_P2 &&
                     state_q != S_T2 && state_q != S_P3 && state_q != S_T3) begin
            state_d = S_WAIT;
        end
    end

    // ------------------------------------------------------------------
    // Decode and sequence registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q     <= '0;
            dir_q       <= DIR_HOLD;
            therm_err_q <= 1'b0;
            step_err_q  <= 1'b0;
            peak_q      <= 1'b0;
            trough_q    <= 1'b0;
            ext_level_q <= '0;
            state_q     <= S_WAIT;
            done_q      <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            therm_err_q <= ~lamp_valid;
            step_err_q  <= step_big;
            peak_q      <= peak_d;
            trough_q    <= trough_d;
            done_q      <= done_d;
            seq_err_q   <= seq_err_d;
            state_q     <= state_d;
            // An illegal sample leaves the tracked level and direction alone.
            if (lamp_valid) begin
                level_q <= new_lvl;
                dir_q   <= new_dir;
            end
            if (peak_d || trough_d) begin
                ext_level_q <= level_q;
            end
        end
    end

    assign level        = level_q;
    assign dir          = dir_q;
    assign therm_err    = therm_err_q;
    assign step_err     = step_err_q;
    assign peak_valid   = peak_q;
    assign trough_valid = trough_q;
    assign ext_level    = ext_level_q;
    assign seq_state    = state_q;
    assign cycle_done   = done_q;
    assign seq_err      = seq_err_q;

    // ------------------------------------------------------------------
    // Optional statistics counters.  They advance on the same edge that
    // registers the corresponding pulse and stick at all-ones.
    // ------------------------------------------------------------------
`ifdef LAMP_SEQ_STATS_EN
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             any_err_d;

    assign any_err_d = ~lamp_valid | step_big | seq_err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (done_d && !(&cycle_cnt_q)) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            if (any_err_d && !(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign cycle_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule
